dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter sharing the single-port data_ram between the two load/store pipes of the dual-issue MiniMIPS32 core. Each cycle it grants at most one pipe, drives the RAM enable, byte-write-enable, word address and write data, and routes the one-cycle-latency read data back to the granted pipe. It sits between the core's two memory-stage ports and the data_ram instance in the SoC, and it keeps a saturating conflict counter for performance debug.

## Interface
- PRIO_MODE, default 1: 0 = fixed priority (m0 always wins), 1 = round-robin.
- RAM_AW, default 16: data_ram word-address width; ram_addr = mX_addr[RAM_AW+1:2].
- CNT_W, default 16: conflict counter width.

- cpu_clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  pipe-0 access request; held with its address and data until m0_gnt
- m0_addr  in  32  byte address, word aligned
- m0_we  in  4  byte write enables; 4'b0000 = read
- m0_wdata  in  32  store data
- m0_gnt  out  1  combinational grant; the access is issued this cycle
- m0_rvalid  out  1  read data valid for pipe 0
- m0_rdata  out  32  read data; 0 when m0_rvalid=0
- m1_req, m1_addr, m1_we, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same for pipe 1
- ram_ce  out  1  data_ram enable
- ram_we  out  4  data_ram byte write enables
- ram_addr  out  RAM_AW  data_ram word address
- ram_wdata  out  32  data_ram write data
- ram_rdata  in  32  data_ram read data, valid one cycle after a read-enable edge
- conflict_cnt  out  CNT_W  cycles with both requests asserted, saturating

## Operation
- Grant, combinational: only m0_req -> m0; only m1_req -> m1; both -> m0 if PRIO_MODE=0, else the port that is not last_gnt.
- last_gnt register, 1 bit: updated to the granted port on every granted cycle and held when idle. It resets to 1, so m0 wins the first round-robin conflict.
- RAM drive: ram_ce = m0_gnt|m1_gnt. ram_we/ram_addr/ram_wdata come from the granted port. When ram_ce=0, ram_we=0 and ram_addr/ram_wdata=0.
- Read tracking registers:
  - rd_pend is set when the granted access has we==0, otherwise cleared.
  - rd_owner is the granted port.
- Response: mX_rvalid = rd_pend & (rd_owner==X). mX_rdata = ram_rdata when mX_rvalid, else 0.
- Writes produce no response. The write completes in the grant cycle.
- Ordering: accesses reach the RAM in grant order. A read granted the cycle after a write to the same word returns the new data, because of the BRAM write-then-read across cycles.
- conflict_cnt increments on every cycle with m0_req&m1_req and stops at all-ones.
- The arbiter does not check alignment. Address bits [1:0] are ignored.

## Timing
- Reset values: last_gnt=1, rd_pend=0, rd_owner=0, conflict_cnt=0. All outputs are 0 during reset: gnt, rvalid and ram_* are gated by reset.
- Grant latency: 0 cycles, same cycle as the request.
- Read data latency: 1 cycle after the grant, with rvalid high for exactly one cycle.
- Throughput: one access per cycle.
- Worst-case wait under contention is 1 cycle in round-robin mode and unbounded for m1 in fixed mode.
- Back-to-back reads by the same port are allowed every cycle. rvalid is then continuous while ownership is unchanged.
- Reset asserted mid-read: the pending response is dropped and no rvalid appears after reset release.
- Request dropped before grant: legal, nothing is issued, and last_gnt is unchanged.

## Test plan
- Single read after reset:
  - Stimulus: preload word 0x10 = 0xDEADBEEF; m0_req, m0_addr=0x40, m0_we=0.
  - Required: m0_gnt=1, ram_ce=1, ram_addr=0x10 in cycle N; m0_rvalid=1, m0_rdata=0xDEADBEEF in N+1; m1_rvalid stays 0.
- Round-robin conflict:
  - Stimulus: PRIO_MODE=1; m0 and m1 both request reads for 4 cycles, held until granted.
  - Required: grants alternate m0, m1, m0, m1; conflict_cnt reaches 4; each rvalid is routed to its own port one cycle after its grant.
- Fixed priority:
  - Stimulus: PRIO_MODE=0; both request continuously for 3 cycles.
  - Required: m0_gnt=1 all 3 cycles, m1_gnt=0, conflict_cnt=3.
- Write then read:
  - Stimulus: cycle N, m1 writes addr 0x80 with m1_we=4'b0011, m1_wdata=0x1234ABCD over old 0xFFFFFFFF; cycle N+1, m0 reads 0x80.
  - Required: m0_rdata=0xFFFFABCD at N+2; no rvalid at N+1.
- Reset mid-read:
  - Stimulus: m1 read is granted in cycle N; reset asserts between N and N+1.
  - Required: m1_rvalid=0 throughout; after release last_gnt=1 and conflict_cnt=0.
- Counter saturation:
  - Stimulus: CNT_W=4; hold a conflict for 20 cycles.
  - Required: conflict_cnt stops at 0xF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-port data_ram between the two load/store pipes of the
// dual-issue core. At most one pipe is granted each cycle. Read data comes back
// one cycle later and is steered to the pipe that issued the read. A saturating
// counter records how many cycles had both pipes requesting.
module dmem_arbiter #(
  parameter int unsigned PRIO_MODE = 1,  // 0: m0 always wins, 1: round-robin
  parameter int unsigned RAM_AW    = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              cpu_clk,
  input  logic              reset,
  // pipe 0
  input  logic              m0_req,
  input  logic [31:0]       m0_addr,
  input  logic [3:0]        m0_we,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  // pipe 1
  input  logic              m1_req,
  input  logic [31:0]       m1_addr,
  input  logic [3:0]        m1_we,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  // data_ram
  output logic              ram_ce,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  // perf debug
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic             last_gnt_q;  // 1 = pipe 1 was granted last
  logic             rd_pend_q;
  logic             rd_owner_q;  // 1 = pending read belongs to pipe 1
  logic [CNT_W-1:0] cnt_q;
  logic             both_req;

  assign both_req = m0_req & m1_req;

  // Byte-offset and upper address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{m0_addr[1:0], m0_addr[31:RAM_AW+2],
                         m1_addr[1:0], m1_addr[31:RAM_AW+2]};

  // Combinational grant; on contention round-robin favours the pipe not granted last.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (m0_req && !m1_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req && !m0_req) begin
        m1_gnt = 1'b1;
      end else if (both_req) begin
        if (PRIO_MODE == 0 || last_gnt_q) begin
          m0_gnt = 1'b1;
        end else begin
          m1_gnt = 1'b1;
        end
      end
    end
  end

  // RAM drive muxed from the granted pipe, all-zero when idle.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    if (m0_gnt) begin
      ram_ce    = 1'b1;
      ram_we    = m0_we;
      ram_addr  = m0_addr[RAM_AW+1:2];
      ram_wdata = m0_wdata;
    end else if (m1_gnt) begin
      ram_ce    = 1'b1;
      ram_we    = m1_we;
      ram_addr  = m1_addr[RAM_AW+1:2];
      ram_wdata = m1_wdata;
    end
  end

  // Arbitration history, read tracking and conflict counter.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      last_gnt_q <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rd_pend_q <= ram_ce && (ram_we == 4'b0000);
      if (ram_ce) begin
        last_gnt_q <= m1_gnt;
        rd_owner_q <= m1_gnt;
      end
      if (both_req && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Route the one-cycle-late read data to its owner; zero otherwise.
  always_comb begin
    m0_rvalid = !reset && rd_pend_q && !rd_owner_q;
    m1_rvalid = !reset && rd_pend_q && rd_owner_q;
    m0_rdata  = m0_rvalid ? ram_rdata : 32'h0;
    m1_rdata  = m1_rvalid ? ram_rdata : 32'h0;
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance backed by a small BRAM model,
// and a fixed-priority instance with a 4-bit counter.
module tb_dmem_arbiter;

  logic cpu_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  // Round-robin instance signals
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_we, m1_we;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce;
  logic [3:0]  ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [15:0] conflict_cnt;

  // Fixed-priority instance signals
  logic        f0_req, f1_req;
  logic        f0_gnt, f1_gnt, f0_rvalid, f1_rvalid;
  logic [31:0] f0_rdata, f1_rdata;
  logic        f_ce;
  logic [3:0]  f_we;
  logic [15:0] f_addr;
  logic [31:0] f_wdata;
  logic [3:0]  f_cnt;

  dmem_arbiter #(.PRIO_MODE(1), .RAM_AW(16), .CNT_W(16)) u_dut (
    .cpu_clk(cpu_clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );

  dmem_arbiter #(.PRIO_MODE(0), .RAM_AW(16), .CNT_W(4)) u_fx (
    .cpu_clk(cpu_clk), .reset(reset),
    .m0_req(f0_req), .m0_addr(32'h0), .m0_we(4'b0000), .m0_wdata(32'h0),
    .m0_gnt(f0_gnt), .m0_rvalid(f0_rvalid), .m0_rdata(f0_rdata),
    .m1_req(f1_req), .m1_addr(32'h4), .m1_we(4'b0000), .m1_wdata(32'h0),
    .m1_gnt(f1_gnt), .m1_rvalid(f1_rvalid), .m1_rdata(f1_rdata),
    .ram_ce(f_ce), .ram_we(f_we), .ram_addr(f_addr), .ram_wdata(f_wdata),
    .ram_rdata(32'h0), .conflict_cnt(f_cnt)
  );

  // BRAM model: read-before-write in the same cycle, contents preloaded while in reset.
  logic [31:0] mem [256];
  always @(posedge cpu_clk) begin
    if (reset) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'hFFFFFFFF;
      mem[8'h40] <= 32'hA0A00000;
      mem[8'h41] <= 32'hA0A00001;
      mem[8'h80] <= 32'hB1B10000;
      mem[8'h81] <= 32'hB1B10001;
    end else if (ram_ce) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic [31:0] data;
  } resp_t;
  resp_t sb[$];
  resp_t mon_r;

  // Monitor: every rvalid must match the oldest expected response.
  always @(negedge cpu_clk) begin
    if (!reset) begin
      if (m0_rvalid || m1_rvalid) begin
        if (sb.size() == 0) begin
          check("unexpected_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        end else begin
          mon_r = sb.pop_front();
          check("rvalid_port", {30'h0, m1_rvalid, m0_rvalid}, mon_r.port ? 32'h2 : 32'h1);
          check("rdata", mon_r.port ? m1_rdata : m0_rdata, mon_r.data);
        end
      end else begin
        check("idle_rdata_zero", m0_rdata | m1_rdata, 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge cpu_clk);
  endtask

  task automatic push(input logic port, input logic [31:0] data);
    resp_t r;
    r.port = port;
    r.data = data;
    sb.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  logic [31:0] d0 [2];
  logic [31:0] d1 [2];
  logic        exp_g [4];

  initial begin
    int i0, i1;
    d0 = '{32'hA0A00000, 32'hA0A00001};
    d1 = '{32'hB1B10000, 32'hB1B10001};
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset: requests asserted but everything gated off
    m0_req = 1'b1; m0_addr = 32'h40; m0_we = 4'b0000; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_addr = 32'h80; m1_we = 4'b0000; m1_wdata = 32'h0;
    f0_req = 1'b0; f1_req = 1'b0;
    sample();
    check("rst_m0_gnt", {31'h0, m0_gnt}, 32'h0);
    check("rst_m1_gnt", {31'h0, m1_gnt}, 32'h0);
    check("rst_ram_ce", {31'h0, ram_ce}, 32'h0);
    check("rst_ram_addr", {16'h0, ram_addr}, 32'h0);
    check("rst_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    step();
    step();
    check("rst_cnt", {16'h0, conflict_cnt}, 32'h0);
    reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;

    // Single read
    step();
    m0_req = 1'b1; m0_addr = 32'h40; m0_we = 4'b0000;
    sample();
    check("rd_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    check("rd_m1_gnt", {31'h0, m1_gnt}, 32'h0);
    check("rd_ram_ce", {31'h0, ram_ce}, 32'h1);
    check("rd_ram_addr", {16'h0, ram_addr}, 32'h10);
    push(1'b0, 32'hDEADBEEF);
    step();
    m0_req = 1'b0;
    sample();
    check("idle_ram_ce", {31'h0, ram_ce}, 32'h0);

    // Partial write by m1, then read by m0
    step();
    m1_req = 1'b1; m1_addr = 32'h80; m1_we = 4'b0011; m1_wdata = 32'h1234ABCD;
    sample();
    check("wr_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    check("wr_ram_we", {28'h0, ram_we}, 32'h3);
    check("wr_ram_addr", {16'h0, ram_addr}, 32'h20);
    check("wr_ram_wdata", ram_wdata, 32'h1234ABCD);
    step();
    m1_req = 1'b0; m1_we = 4'b0000;
    m0_req = 1'b1; m0_addr = 32'h80; m0_we = 4'b0000;
    sample();
    check("wr_rd_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    push(1'b0, 32'hFFFFABCD);
    step();
    m0_req = 1'b0;
    sample();

    // Reset during an outstanding m1 read
    step();
    m1_req = 1'b1; m1_addr = 32'h40; m1_we = 4'b0000;
    sample();
    check("rmr_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    @(posedge cpu_clk);
    #2;
    reset = 1'b1; m1_req = 1'b0;
    sample();
    check("rmr_rvalid_in_reset", {31'h0, m1_rvalid}, 32'h0);
    step();
    step();
    reset = 1'b0;
    sample();
    check("rmr_rvalid_after", {31'h0, m1_rvalid}, 32'h0);
    check("rmr_cnt", {16'h0, conflict_cnt}, 32'h0);
    step();
    sample();
    check("rmr_rvalid_later", {31'h0, m1_rvalid}, 32'h0);

    // Round-robin contention: m0 wins first since last_gnt resets to 1
    i0 = 0; i1 = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      m0_req = 1'b1; m0_addr = 32'h100 + 32'(4 * i0); m0_we = 4'b0000;
      m1_req = 1'b1; m1_addr = 32'h200 + 32'(4 * i1); m1_we = 4'b0000;
      sample();
      check($sformatf("rr_m0_gnt_%0d", k), {31'h0, m0_gnt}, {31'h0, !exp_g[k]});
      check($sformatf("rr_m1_gnt_%0d", k), {31'h0, m1_gnt}, {31'h0, exp_g[k]});
      if (exp_g[k]) begin
        push(1'b1, d1[i1]);
        i1++;
      end else begin
        push(1'b0, d0[i0]);
        i0++;
      end
    end
    step();
    m0_req = 1'b0; m1_req = 1'b0;
    sample();
    check("rr_cnt", {16'h0, conflict_cnt}, 32'h4);
    step();
    sample();

    // Fixed priority and 4-bit counter saturation
    for (int k = 0; k < 20; k++) begin
      step();
      f0_req = 1'b1; f1_req = 1'b1;
      sample();
      if (k < 3) begin
        check($sformatf("fx_m0_gnt_%0d", k), {31'h0, f0_gnt}, 32'h1);
        check($sformatf("fx_m1_gnt_%0d", k), {31'h0, f1_gnt}, 32'h0);
        check($sformatf("fx_cnt_%0d", k), {28'h0, f_cnt}, k);
      end
      if (k == 15 || k == 19) begin
        check($sformatf("sat_cnt_%0d", k), {28'h0, f_cnt}, 32'hF);
      end
    end
    step();
    f0_req = 1'b0; f1_req = 1'b0;
    sample();
    check("sat_cnt_final", {28'h0, f_cnt}, 32'hF);
    check("fx_after_idle_gnt", {30'h0, f1_gnt, f0_gnt}, 32'h0);

    step();
    sample();
    check("scoreboard_drained", sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
